// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the writeback arbiter: widths, x0 constant and
// the writeback entry carried through the LL FIFO and the output register.
package wb_arbiter_pkg;

  localparam int XLEN_D       = 32;
  localparam int ADDR_WIDTH_D = 5;
  localparam int FIFO_DEPTH_D = 2;

  localparam logic [ADDR_WIDTH_D-1:0] X0 = '0;

  // src_ll marks LL-sourced writes so the scoreboard knows which writes retire a busy bit.
  typedef struct packed {
    logic [ADDR_WIDTH_D-1:0] addr;
    logic [XLEN_D-1:0]       data;
    logic                    src_ll;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous-write FIFO with extra-MSB wrap pointers; head is read
// combinationally so the arbiter can forward it in the same cycle it pops.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Equal index with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline writeback and long-latency results into the single Regfile
// write port, and tracks registers with outstanding LL results for decode stall.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_pipeWrEn,
  input  logic [ADDR_WIDTH-1:0] i_pipeRdAddr,
  input  logic [XLEN-1:0]       i_pipeRdData,
  input  logic                  i_llIssue,
  input  logic [ADDR_WIDTH-1:0] i_llIssueRd,
  input  logic                  i_llValid,
  output logic                  o_llReady,
  input  logic [ADDR_WIDTH-1:0] i_llRdAddr,
  input  logic [XLEN-1:0]       i_llData,
  input  logic [ADDR_WIDTH-1:0] i_rs1Addr,
  input  logic [ADDR_WIDTH-1:0] i_rs2Addr,
  input  logic [ADDR_WIDTH-1:0] i_rdAddr,
  output logic                  o_stall,
  output logic                  o_wrEn,
  output logic [ADDR_WIDTH-1:0] o_rdAddr,
  output logic [XLEN-1:0]       o_rdData
);

  localparam int NREG = 2**ADDR_WIDTH;

  wb_entry_t       fifo_head;
  wb_entry_t       ll_entry;
  wb_entry_t       win;
  wb_entry_t       out_q;
  logic            win_valid;
  logic            wr_en_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            ll_accept;
  logic            pipe_live;
  logic            ll_live;
  logic [NREG-1:0] busy;

  // LL handshake: a result transfers on a cycle where i_llValid and o_llReady are
  // both high; o_llReady depends only on FIFO occupancy, never on i_llValid.
  assign o_llReady = ~fifo_full;
  assign ll_accept = i_llValid & ~fifo_full;
  assign pipe_live = i_pipeWrEn & (i_pipeRdAddr != X0);
  assign ll_live   = ll_accept & (i_llRdAddr != X0);
  assign ll_entry  = '{addr: i_llRdAddr, data: i_llData, src_ll: 1'b1};

  wb_fifo #(
    .WIDTH($bits(wb_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (i_clk),
    .rst_n(i_rstn),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(ll_entry),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Bypass only with an empty FIFO so a new LL result never overtakes buffered ones.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    if (pipe_live) begin
      win       = '{addr: i_pipeRdAddr, data: i_pipeRdData, src_ll: 1'b0};
      win_valid = 1'b1;
      fifo_push = ll_live;
    end else if (!fifo_empty) begin
      win       = fifo_head;
      win_valid = 1'b1;
      fifo_pop  = 1'b1;
      fifo_push = ll_live;
    end else if (ll_live) begin
      win       = ll_entry;
      win_valid = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_en_q <= 1'b0;
      out_q   <= '0;
    end else begin
      wr_en_q <= win_valid;
      out_q   <= win;
    end
  end

  // Set is applied after clear so a same-address issue survives the retiring write.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      busy <= '0;
    end else begin
      if (wr_en_q && out_q.src_ll) busy[out_q.addr] <= 1'b0;
      if (i_llIssue && (i_llIssueRd != X0)) busy[i_llIssueRd] <= 1'b1;
    end
  end

  assign o_stall  = busy[i_rs1Addr] | busy[i_rs2Addr] | busy[i_rdAddr];
  assign o_wrEn   = wr_en_q;
  assign o_rdAddr = out_q.addr;
  assign o_rdData = out_q.data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based model compared every cycle, plus directed
// scenarios with literal expectations and a short random soak.
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic            clk;
  logic            rstn;
  logic            pipe_wr_en;
  logic [AW-1:0]   pipe_rd_addr;
  logic [XLEN-1:0] pipe_rd_data;
  logic            ll_issue;
  logic [AW-1:0]   ll_issue_rd;
  logic            ll_valid;
  logic            ll_ready;
  logic [AW-1:0]   ll_rd_addr;
  logic [XLEN-1:0] ll_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [AW-1:0]   rd_addr;
  logic            stall;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_pipeWrEn  (pipe_wr_en),
    .i_pipeRdAddr(pipe_rd_addr),
    .i_pipeRdData(pipe_rd_data),
    .i_llIssue   (ll_issue),
    .i_llIssueRd (ll_issue_rd),
    .i_llValid   (ll_valid),
    .o_llReady   (ll_ready),
    .i_llRdAddr  (ll_rd_addr),
    .i_llData    (ll_data),
    .i_rs1Addr   (rs1_addr),
    .i_rs2Addr   (rs2_addr),
    .i_rdAddr    (rd_addr),
    .o_stall     (stall),
    .o_wrEn      (wr_en),
    .o_rdAddr    (wr_addr),
    .o_rdData    (wr_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Regfile stand-in and write log
  logic [XLEN-1:0] rf [32];
  logic [AW-1:0]   wr_log [$];
  always @(posedge clk) begin
    if (rstn && wr_en) begin
      rf[wr_addr] <= wr_data;
      wr_log.push_back(wr_addr);
    end
  end

  // Model: pending LL results in arrival order, busy set, expected output register
  logic [AW+XLEN-1:0] exp_q [$];
  bit                 busy_m [32];
  logic               m_wr;
  logic               m_ll;
  logic [AW-1:0]      m_addr;
  logic [XLEN-1:0]    m_data;
  bit                 m_acc;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
      m_wr = 1'b0; m_ll = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      m_acc = ll_valid && (exp_q.size() < DEPTH);
      if (m_wr && m_ll) busy_m[m_addr] = 1'b0;
      m_wr = 1'b0;
      m_ll = 1'b0;
      if (pipe_wr_en && pipe_rd_addr != 0) begin
        m_wr = 1'b1; m_addr = pipe_rd_addr; m_data = pipe_rd_data;
      end else if (exp_q.size() > 0) begin
        {m_addr, m_data} = exp_q.pop_front();
        m_wr = 1'b1; m_ll = 1'b1;
      end else if (m_acc && ll_rd_addr != 0) begin
        m_wr = 1'b1; m_ll = 1'b1; m_addr = ll_rd_addr; m_data = ll_data;
        m_acc = 1'b0;
      end
      if (m_acc && ll_rd_addr != 0) exp_q.push_back({ll_rd_addr, ll_data});
      if (ll_issue && ll_issue_rd != 0) busy_m[ll_issue_rd] = 1'b1;
    end
  end

  // Scoreboard compare, every cycle out of reset
  always @(negedge clk) begin
    if (rstn) begin
      check("wr_en", wr_en, m_wr);
      if (m_wr) begin
        check("wr_addr", wr_addr, m_addr);
        check("wr_data", wr_data, m_data);
      end
      check("ll_ready", ll_ready, exp_q.size() < DEPTH);
      check("stall", stall, busy_m[rs1_addr] | busy_m[rs2_addr] | busy_m[rd_addr]);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wr_en = 0; pipe_rd_addr = 0; pipe_rd_data = 0;
    ll_issue = 0; ll_issue_rd = 0;
    ll_valid = 0; ll_rd_addr = 0; ll_data = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
  endtask

  task automatic drive_pipe(input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    pipe_wr_en = en; pipe_rd_addr = a; pipe_rd_data = d;
  endtask

  task automatic drive_ll(input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    ll_valid = v; ll_rd_addr = a; ll_data = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_wr_addr"}, wr_addr, 5'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_ll_ready"}, ll_ready, 1'b1);
    check({tag, "_stall"}, stall, 1'b0);
  endtask

  int exp_order [5] = '{3, 10, 11, 7, 8};

  initial begin
    idle_inputs();
    rstn = 1'b0;
    drive_pipe(1'b1, 5'd5, 32'h1);

    // Reset with a pipeline write held active
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    idle_inputs();
    rstn = 1'b1;
    tick();

    // Pipeline pass-through
    drive_pipe(1'b1, 5'd5, 32'hdeadbeef);
    tick();
    drive_pipe(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("pipe_wr_en", wr_en, 1'b1);
    check("pipe_addr", wr_addr, 5'd5);
    check("pipe_data", wr_data, 32'hdeadbeef);
    tick();
    check("pipe_rf5", rf[5], 32'hdeadbeef);

    // Collision: LL results buffered behind busy pipeline, order kept
    wr_log.delete();
    drive_pipe(1'b1, 5'd3, 32'h8badf00d);
    drive_ll(1'b1, 5'd7, 32'hcafebabe);
    tick();
    drive_pipe(1'b1, 5'd10, 32'h0000000a);
    drive_ll(1'b1, 5'd8, 32'hcafed00d);
    tick();
    drive_ll(1'b0, 5'd0, 32'h0);
    drive_pipe(1'b1, 5'd11, 32'h0000000b);
    @(negedge clk);
    check("coll_ready_full", ll_ready, 1'b0);
    tick();
    drive_pipe(1'b0, 5'd0, 32'h0);
    repeat (4) tick();
    check("coll_log_size", wr_log.size(), 5);
    for (int i = 0; i < 5; i++) check("coll_order", wr_log[i], exp_order[i]);
    check("coll_rf7", rf[7], 32'hcafebabe);
    check("coll_rf8", rf[8], 32'hcafed00d);

    // Scoreboard: RAW stall on x9 until the LL write retires it
    ll_issue = 1'b1; ll_issue_rd = 5'd9;
    tick();
    ll_issue = 1'b0; ll_issue_rd = 5'd0;
    rs1_addr = 5'd9;
    @(negedge clk);
    check("sb_stall_set", stall, 1'b1);
    tick();
    tick();
    @(negedge clk);
    check("sb_stall_hold", stall, 1'b1);
    drive_ll(1'b1, 5'd9, 32'h00c0ffee);
    tick();
    drive_ll(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("sb_stall_at_write", stall, 1'b1);
    check("sb_wr_addr", wr_addr, 5'd9);
    tick();
    @(negedge clk);
    check("sb_stall_clear", stall, 1'b0);
    check("sb_rf9", rf[9], 32'h00c0ffee);
    rs1_addr = 5'd0;
    tick();

    // x0: issue and result both dropped, result still accepted
    ll_issue = 1'b1; ll_issue_rd = 5'd0;
    tick();
    ll_issue = 1'b0;
    drive_ll(1'b1, 5'd0, 32'hffffffff);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("x0_stall", stall, 1'b0);
      check("x0_wr_en", wr_en, 1'b0);
      check("x0_ready", ll_ready, 1'b1);
      tick();
      drive_ll(1'b0, 5'd0, 32'h0);
    end

    // Reset mid-operation with two buffered entries and busy x4
    ll_issue = 1'b1; ll_issue_rd = 5'd4;
    drive_pipe(1'b1, 5'd12, 32'hc);
    drive_ll(1'b1, 5'd13, 32'hd);
    tick();
    ll_issue = 1'b0; ll_issue_rd = 5'd0;
    drive_pipe(1'b1, 5'd14, 32'he);
    drive_ll(1'b1, 5'd15, 32'hf);
    tick();
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_ll(1'b0, 5'd0, 32'h0);
    rs1_addr = 5'd4;
    @(negedge clk);
    check("mid_ready_full", ll_ready, 1'b0);
    check("mid_stall", stall, 1'b1);
    check("mid_wr_en", wr_en, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    wr_log.delete();
    repeat (5) tick();
    check("mid_no_write", wr_log.size(), 0);
    rs1_addr = 5'd0;

    // Random soak against the model
    for (int i = 0; i < 300; i++) begin
      drive_pipe($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      drive_ll($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      ll_issue    = ($urandom_range(0, 3) == 0);
      ll_issue_rd = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      rd_addr     = 5'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
